sio_uart_tx: RTL and testbench

- Transmit side of the SIO/serial link that drives the board's `UART_TX` pin; the counterpart to the existing receive path on `UART_RX`.
- Accepts bytes from the core over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 (or 8-parity-1 with the option compiled in), LSB first, at a runtime-programmable bit period.
- Sits in `clk_sys` domain beside the core's SIO logic; output registered and routed straight to the pin.

---
 rtl/sio_uart_pkg.sv | 27 ++
 rtl/sio_uart_fifo.sv | 60 ++++++
 rtl/sio_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_sio_uart_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_uart_pkg.sv
// sio_uart_pkg: shared types and constants for the SIO UART transmit/receive paths.
// Optional build macro used by sio_uart_tx: SIO_UART_TX_PARITY_EN.
package sio_uart_pkg;

    // Transmit frame sequencer states; PARITY is only reachable in parity builds
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // clk_sys rates for the two video standards and the resulting 19200 baud divisors
    localparam int unsigned CLK_SYS_NTSC_HZ = 21_477_272;
    localparam int unsigned CLK_SYS_PAL_HZ  = 21_281_370;
    localparam int unsigned BAUD_19200      = 19_200;

    localparam logic [15:0] DIV_19200_NTSC =
        16'((CLK_SYS_NTSC_HZ + BAUD_19200 / 2) / BAUD_19200 - 1);
    localparam logic [15:0] DIV_19200_PAL =
        16'((CLK_SYS_PAL_HZ + BAUD_19200 / 2) / BAUD_19200 - 1);

endpackage

// File: rtl/sio_uart_fifo.sv
// sio_uart_fifo: single-clock byte FIFO with occupancy count, shared by the SIO UART paths.
// Read data is show-ahead: pop_data always presents the head entry.
module sio_uart_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    // Writes into a full FIFO and reads from an empty one are ignored
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array carries data only, so it is left out of reset
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sio_uart_tx.sv
// sio_uart_tx: byte-wide valid/ready input, FIFO buffered, 8N1 serialiser driving UART_TX.
// Define SIO_UART_TX_PARITY_EN to add a parity bit (port parity_odd, 11-bit frames).
module sio_uart_tx
    import sio_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
`ifdef SIO_UART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0]  BIT_ONE  = BC_W'(1);
    localparam logic [DIV_W-1:0] BAUD_ONE = DIV_W'(1);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       baud_cnt, baud_d;
    logic [BC_W-1:0]        bit_cnt, bit_d;
    logic                   tx_q, tx_d;
`ifdef SIO_UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic                   fifo_pop;
    logic [7:0]             fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_end;
    logic                   start_frame;

    sio_uart_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (data_valid && !fifo_full),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_ready = !fifo_full;
    assign uart_tx    = tx_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign bit_end    = (baud_cnt == '0);

    // A new frame starts from IDLE, or straight out of the stop bit when more bytes wait
    assign start_frame = !fifo_empty &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // Next-state, bit timing, shift register and line level
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        baud_d   = baud_cnt;
        bit_d    = bit_cnt;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef SIO_UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = div_q;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt - BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = div_q;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SIO_UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_cnt + BIT_ONE;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_cnt - BAUD_ONE;
                end
            end
`ifdef SIO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    baud_d  = div_q;
                    state_d = STOP;
                end else begin
                    baud_d = baud_cnt - BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_cnt - BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Frame start overrides the above: pop head, freeze divisor for the whole frame
        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            div_d    = divisor;
            baud_d   = divisor;
            tx_d     = 1'b0;
            state_d  = START;
`ifdef SIO_UART_TX_PARITY_EN
            par_d    = (^fifo_data) ^ parity_odd;
`endif
        end
    end

    // Control state: sequencer, counters and the registered line output
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
        end
    end

    // Frame data: only meaningful once a frame has been started, so not reset
    always_ff @(posedge clk_sys) begin
        shift_q <= shift_d;
        div_q   <= div_d;
`ifdef SIO_UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

endmodule

// File: tb/tb_sio_uart_tx.sv
// tb_sio_uart_tx: directed + randomised bench for sio_uart_tx with a bit-level line model.
// Honours SIO_UART_TX_PARITY_EN when the design is built with parity.
module tb_sio_uart_tx;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] divisor;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        uart_tx;
    logic        busy;
    logic [4:0]  fifo_count;
`ifdef SIO_UART_TX_PARITY_EN
    logic        parity_odd;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_q [$];
    logic model_odd = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sio_uart_tx #(
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .divisor    (divisor),
`ifdef SIO_UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, one entry per clock: start, 8 data LSB first, [parity], stop
    function automatic void add_frame(input logic [7:0] b, input int div);
        logic fb [$];
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(((b >> i) & 8'd1) != 8'd0);
`ifdef SIO_UART_TX_PARITY_EN
        fb.push_back((($countones(b) % 2) == 1) ^ model_odd);
`endif
        fb.push_back(1'b1);
        foreach (fb[j])
            for (int c = 0; c <= div; c++) exp_q.push_back(fb[j]);
    endfunction

    task automatic step_check(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty expectation queue expected entries", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, uart_tx, e);
            chk({tag, "_busy"}, busy, 1);
        end
        @(negedge clk_sys);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) step_check(tag);
    endtask

    task automatic push_one(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk_sys);
        data_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_tx"}, uart_tx, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_cnt"}, fifo_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, b2;
        logic [7:0] acc [$];
        int d, n, model_cnt;

        reset      = 1'b1;
        divisor    = 16'd0;
        data_in    = 8'd0;
        data_valid = 1'b0;
`ifdef SIO_UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);

        // Reset values
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_ready", data_ready, 1);
        reset = 1'b0;
        @(negedge clk_sys);
        chk_idle("post_rst");

        // Single byte 0xA5, 4 clocks per bit, one cycle of latency before the start bit
        divisor = 16'd3;
        exp_q.push_back(1'b1);
        add_frame(8'hA5, 3);
        push_one(8'hA5);
        chk("single_cnt", fifo_count, 1);
        chk("single_ready", data_ready, 1);
        drain("single");
        chk_idle("single");

        // Random single frames with random divisors
        for (int t = 0; t < 6; t++) begin
            b = 8'($urandom);
            d = int'($urandom_range(0, 4));
            divisor = 16'(d);
            exp_q.push_back(1'b1);
            add_frame(b, d);
            push_one(b);
            drain("rand_single");
            chk_idle("rand_single");
        end

        // Back-to-back 0x00 then 0xFF at 1 clock per bit, no gap
        divisor = 16'd0;
        exp_q.push_back(1'b1);
        add_frame(8'h00, 0);
        add_frame(8'hFF, 0);
        data_in    = 8'h00;
        data_valid = 1'b1;
        @(negedge clk_sys);
        data_in = 8'hFF;
        step_check("b2b");
        data_valid = 1'b0;
        chk("b2b_cnt_pushpop", fifo_count, 1);
        drain("b2b");
        chk_idle("b2b");

        // Random bursts pushed on consecutive cycles
        for (int t = 0; t < 3; t++) begin
            n = int'($urandom_range(2, 5));
            d = int'($urandom_range(0, 3));
            divisor = 16'(d);
            exp_q.push_back(1'b1);
            b = 8'($urandom);
            add_frame(b, d);
            data_in    = b;
            data_valid = 1'b1;
            @(negedge clk_sys);
            for (int i = 1; i < n; i++) begin
                b = 8'($urandom);
                add_frame(b, d);
                data_in = b;
                step_check("burst");
            end
            data_valid = 1'b0;
            drain("burst");
            chk_idle("burst");
        end

        // Divisor change mid-frame: current frame keeps 8 clocks/bit, next uses 2
        divisor = 16'd7;
        b  = 8'($urandom);
        b2 = 8'($urandom);
        exp_q.push_back(1'b1);
        add_frame(b, 7);
        add_frame(b2, 1);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk_sys);
        data_in = b2;
        step_check("divchg");
        data_valid = 1'b0;
        repeat (19) step_check("divchg");
        divisor = 16'd1;
        drain("divchg");
        chk_idle("divchg");

        // FIFO full: slow frame in flight, then 17 pushes of which 16 are accepted
        divisor = 16'd100;
        b = 8'($urandom);
        exp_q.push_back(1'b1);
        add_frame(b, 100);
        push_one(b);
        step_check("full");
        model_cnt = 0;
        acc.delete();
        for (int i = 0; i < 17; i++) begin
            chk("full_ready", data_ready, (model_cnt < 16) ? 1 : 0);
            data_in    = 8'($urandom);
            data_valid = 1'b1;
            if (model_cnt < 16) begin
                acc.push_back(data_in);
                model_cnt++;
            end
            step_check("full");
        end
        data_valid = 1'b0;
        chk("full_cnt", fifo_count, model_cnt);
        chk("full_ready_end", data_ready, 0);
        divisor = 16'd0;
        foreach (acc[i]) add_frame(acc[i], 0);
        drain("full_order");
        chk_idle("full");

        // Reset during DATA with bytes queued
        divisor = 16'd3;
        exp_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) add_frame(8'($urandom), 3);
        data_in    = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk_sys);
        data_in = 8'h5A;
        step_check("rstmid_pre");
        data_in = 8'hC3;
        step_check("rstmid_pre");
        data_valid = 1'b0;
        exp_q.delete();
        repeat (12) @(negedge clk_sys);
        chk("rstmid_cnt_before", fifo_count, 2);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("rstmid_tx", uart_tx, 1);
        chk("rstmid_cnt", fifo_count, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", data_ready, 1);
        for (int i = 0; i < 40; i++) begin
            chk("rstmid_quiet", uart_tx, 1);
            @(negedge clk_sys);
        end
        chk_idle("rstmid");

`ifdef SIO_UART_TX_PARITY_EN
        // Parity bit for 0x07: even parity gives 1, odd parity gives 0
        divisor    = 16'd2;
        parity_odd = 1'b0;
        model_odd  = 1'b0;
        exp_q.push_back(1'b1);
        add_frame(8'h07, 2);
        push_one(8'h07);
        drain("parity_even");
        chk_idle("parity_even");
        parity_odd = 1'b1;
        model_odd  = 1'b1;
        exp_q.push_back(1'b1);
        add_frame(8'h07, 2);
        push_one(8'h07);
        drain("parity_odd");
        chk_idle("parity_odd");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
